// File: rtl/ctrl_gen_pkg.sv
// ctrl_gen_pkg: shared FSM state and framing types for ctrl_bus sources.
package ctrl_gen_pkg;
    typedef enum logic [1:0] {IDLE, START, RUN, STOP} ctrl_state_e;
    typedef struct packed {
        logic start;
        logic valid;
        logic stop;
    } ctrl_reg;
endpackage

// File: rtl/ctrl_bus.sv
// ctrl_bus: start/valid/stop framing between a ctrl source and its consumers.
interface ctrl_bus;
    logic start;
    logic valid;
    logic stop;
    modport out(output start, output valid, output stop);
    modport in(input start, input valid, input stop);
endinterface

// File: rtl/ctrl_delay.sv
// ctrl_delay: plain shift register aligning framing and done with a fixed-depth datapath.
module ctrl_delay
    import ctrl_gen_pkg::*;
#(
    parameter int LATENCY = 0
) (
    input  logic    clk,
    input  logic    rst,
    input  ctrl_reg d,
    input  logic    d_done,
    output ctrl_reg q,
    output logic    q_done
);
    if (LATENCY == 0) begin : g_wire
        logic unused;
        assign unused = clk ^ rst;
        assign q = d;
        assign q_done = d_done;
    end else begin : g_pipe
        logic [3:0] pipe [LATENCY];
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
            end else begin
                pipe[0] <= {d, d_done};
                for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
            end
        end
        assign {q, q_done} = pipe[LATENCY-1];
    end
endmodule

// File: rtl/ctrl_gen.sv
// ctrl_gen: emits one start / len beats / stop burst per request on a ctrl_bus source port.
module ctrl_gen
    import ctrl_gen_pkg::*;
#(
    parameter int LENWIDTH = 16,
    parameter int LATENCY  = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req,
    input  logic [LENWIDTH-1:0] len,
    input  logic                stall,
    ctrl_bus.out                ctrl,
    output logic [LENWIDTH-1:0] count,
    output logic                busy,
    output logic                done
);
    ctrl_state_e         state, state_n;
    ctrl_reg             raw, raw_n, dly;
    logic                done_r, done_n, busy_n;
    logic [LENWIDTH-1:0] count_n, len_q, len_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            raw    <= '0;
            done_r <= 1'b0;
            busy   <= 1'b0;
            count  <= '0;
            len_q  <= '0;
        end else begin
            state  <= state_n;
            raw    <= raw_n;
            done_r <= done_n;
            busy   <= busy_n;
            count  <= count_n;
            len_q  <= len_n;
        end
    end

    // Outputs are computed for the coming cycle; a beat is "issued" when raw.valid is high.
    always_comb begin
        state_n = state;
        raw_n   = '0;
        done_n  = 1'b0;
        busy_n  = 1'b0;
        count_n = count;
        len_n   = len_q;
        case (state)
            IDLE: begin
                if (req && len != '0) begin
                    state_n     = START;
                    raw_n.start = 1'b1;
                    busy_n      = 1'b1;
                    count_n     = '0;
                    len_n       = len;
                end
            end
            START: begin
                state_n     = RUN;
                raw_n.valid = ~stall;
                busy_n      = 1'b1;
                count_n     = '0;
            end
            RUN: begin
                busy_n = 1'b1;
                if (raw.valid && count == len_q - LENWIDTH'(1)) begin
                    state_n    = STOP;
                    raw_n.stop = 1'b1;
                    done_n     = 1'b1;
                end else begin
                    raw_n.valid = ~stall;
                    count_n     = raw.valid ? count + LENWIDTH'(1) : count;
                end
            end
            STOP: begin
                state_n = IDLE;
                count_n = '0;
            end
            default: state_n = IDLE;
        endcase
    end

    ctrl_delay #(.LATENCY(LATENCY)) u_delay (
        .clk    (clk),
        .rst    (rst),
        .d      (raw),
        .d_done (done_r),
        .q      (dly),
        .q_done (done)
    );

    assign ctrl.start = dly.start;
    assign ctrl.valid = dly.valid;
    assign ctrl.stop  = dly.stop;
endmodule

// File: tb/tb_ctrl_gen.sv
// tb_ctrl_gen: scoreboard bench driving LATENCY=0 and LATENCY=2 instances with identical stimulus.
module tb_ctrl_gen;
    typedef struct {
        int cyc;
        int v;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic [15:0] len = '0;
    logic        stall = 1'b0;
    logic [15:0] count0, count2;
    logic        busy0, busy2, done0, done2;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          cr = 32'h7fffffff;
    rec_t        ev0[$], ev2[$], st0[$], st2[$];

    ctrl_bus b0();
    ctrl_bus b2();

    ctrl_gen #(.LENWIDTH(16), .LATENCY(0)) dut0 (
        .clk(clk), .rst(rst), .req(req), .len(len), .stall(stall),
        .ctrl(b0), .count(count0), .busy(busy0), .done(done0)
    );
    ctrl_gen #(.LENWIDTH(16), .LATENCY(2)) dut2 (
        .clk(clk), .rst(rst), .req(req), .len(len), .stall(stall),
        .ctrl(b2), .count(count2), .busy(busy2), .done(done2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask

    // Event bits are {start, valid, stop, done}; the LATENCY=2 copy sees them two cycles later.
    task automatic pev(input int c, input int bits);
        ev0.push_back('{c, bits});
        if (c + 2 <= cr) ev2.push_back('{c + 2, bits});
    endtask

    task automatic pst(input int c, input int cnt);
        st0.push_back('{c, cnt});
        st2.push_back('{c, cnt});
    endtask

    task automatic mon(input string nm, input logic [3:0] bits, input logic bsy, input int cnt,
                       inout rec_t evq[$], inout rec_t stq[$]);
        rec_t r;
        if (bits != 4'b0000) begin
            if (evq.size() == 0) chk({nm, "_unexpected_event"}, int'(bits), 0);
            else begin
                r = evq.pop_front();
                chk({nm, "_event_cycle"}, cyc, r.cyc);
                chk({nm, "_event_bits"}, int'(bits), r.v);
            end
        end
        if (bsy) begin
            if (stq.size() == 0) chk({nm, "_unexpected_busy"}, 1, 0);
            else begin
                r = stq.pop_front();
                chk({nm, "_busy_cycle"}, cyc, r.cyc);
                chk({nm, "_count"}, cnt, r.v);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon("lat0", {b0.start, b0.valid, b0.stop, done0}, busy0, int'(count0), ev0, st0);
            mon("lat2", {b2.start, b2.valid, b2.stop, done2}, busy2, int'(count2), ev2, st2);
        end
    end

    task automatic chk_idle(input string nm);
        chk({nm, "_lat0_outs"}, int'({b0.start, b0.valid, b0.stop, done0, busy0}), 0);
        chk({nm, "_lat0_count"}, int'(count0), 0);
        chk({nm, "_lat2_outs"}, int'({b2.start, b2.valid, b2.stop, done2, busy2}), 0);
        chk({nm, "_lat2_count"}, int'(count2), 0);
    endtask

    // n beats; smask bit k stalls RUN cycle k; rnd picks random stalls; inj re-requests on RUN cycle inj;
    // ab >= 0 asserts rst right after the beat with count ab is visible.
    task automatic burst(input int n, input logic [31:0] smask, input bit rnd, input int inj, input int ab);
        int cs, k, beats;
        bit s;
        @(negedge clk);
        req = 1'b1;
        len = 16'(n);
        stall = 1'($urandom_range(0, 1));
        if (n == 0) begin
            @(negedge clk);
            req = 1'b0;
            repeat (3) @(negedge clk);
            return;
        end
        cs = cyc + 1;
        cr = (ab >= 0) ? cs + ab + 1 : 32'h7fffffff;
        pev(cs, 4'b1000);
        pst(cs, 0);
        k = 1;
        beats = 0;
        while (beats < n) begin
            @(negedge clk);
            req = (k == inj);
            len = (k == inj) ? 16'd2 : 16'(n);
            s = rnd ? ($urandom_range(0, 3) == 0) : (k < 32 && smask[k]);
            stall = s;
            pst(cyc + 1, beats);
            if (!s) begin
                pev(cyc + 1, 4'b0100);
                beats++;
            end
            k++;
            if (ab >= 0 && beats == ab + 1) begin
                @(negedge clk);
                #1 rst = 1'b1;
                #1 chk_idle("abort");
                @(negedge clk);
                rst = 1'b0;
                cr = 32'h7fffffff;
                return;
            end
        end
        @(negedge clk);
        req = 1'b0;
        stall = 1'($urandom_range(0, 1));
        pev(cyc + 1, 4'b0011);
        pst(cyc + 1, n - 1);
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_idle("reset");
        rst = 1'b0;
        burst(4, 32'h0, 1'b0, -1, -1);
        burst(3, 32'h4, 1'b0, -1, -1);
        burst(0, 32'h0, 1'b0, -1, -1);
        burst(5, 32'h0, 1'b0, 3, -1);
        burst(2, 32'h0, 1'b0, -1, -1);
        burst(8, 32'h0, 1'b0, -1, 3);
        burst(2, 32'h0, 1'b0, -1, -1);
        burst(6, 32'h2a, 1'b0, -1, -1);
        burst(1, 32'h6, 1'b0, -1, -1);
        for (int i = 0; i < 1000; i++)
            burst((i % 50 == 0) ? $urandom_range(1, 300) : $urandom_range(1, 24), 32'h0, 1'b1, -1, -1);
        repeat (5) @(negedge clk);
        chk("ev0_leftover", ev0.size(), 0);
        chk("ev2_leftover", ev2.size(), 0);
        chk("st0_leftover", st0.size(), 0);
        chk("st2_leftover", st2.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ctrl_gen.md
Name: ctrl_gen

Overview:
Source end of the ctrl_bus protocol. On a request it produces one framed burst on a ctrl_bus.out modport: a one-cycle start pulse, then exactly len valid beats (stall inserts gaps), then a one-cycle stop pulse. A beat index is provided for address generation. An optional delay line aligns the framing with a downstream datapath of fixed depth. It sits at the head of each layer pipeline (conv/pool/full) and feeds the stages that consume ctrl_bus.in.

Parameters:
LENWIDTH, 16, width of burst length and beat counter; max burst 2^LENWIDTH-1
LATENCY, 0, extra register stages applied to start/valid/stop/done (0 = no extra delay)

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  reset, asynchronous, active-high
req  input  1  burst request, sampled in IDLE only
len  input  LENWIDTH  burst length, sampled with req
stall  input  1  holds the burst; gaps valid during RUN
ctrl  output  ctrl_bus.out  start/valid/stop framing, delayed by LATENCY
count  output  LENWIDTH  index of the current beat (undelayed), 0..len-1
busy  output  1  high from START through STOP inclusive (undelayed)
done  output  1  one-cycle pulse aligned with the delayed stop

Behaviour:
- Reset (async, rst=1): state IDLE; start/valid/stop/done=0; count=0; busy=0; len_q=0; all delay-line stages cleared. rst asserted mid-burst aborts it immediately; no stop or done is issued.
- Raw start/valid/stop/done/count/busy are registered outputs of the FSM. ctrl and done then pass through LATENCY further flops; count and busy bypass the delay line.
- IDLE: req=1 and len!=0 -> latch len_q=len, next state START. req=1 with len==0 is ignored: nothing is emitted and done is not pulsed.
- START (1 cycle): start=1, valid=0, busy=1, count=0 -> RUN. stall is ignored.
- RUN: valid=~stall. count advances by 1 on each beat with valid=1. When the beat with count==len_q-1 is issued, next state is STOP and count holds its value. Stalled cycles do not advance count or state.
- STOP (1 cycle): stop=1, valid=0, raw done=1 -> IDLE. stall is ignored.
- The stop cycle always follows the last valid beat directly. start, valid and stop are never asserted together.
- req while busy=1 is ignored and not queued. A new req in the first IDLE cycle after STOP is accepted, giving back-to-back bursts with at least one idle cycle between stop and the next start.
- Burst length on the wire is exactly len_q valid cycles, independent of the stall pattern. Counter width is LENWIDTH and never wraps inside a burst.
- The delay line is a plain shift register with no stall dependence; the downstream stage must tolerate gaps in valid.

Decomposition:
- ctrl_bus interface and ctrl_reg struct stay in the existing common header.
- A shared package holds the FSM state enum (IDLE, START, RUN, STOP) for reuse by other ctrl sources.
- One natural sub-module is ctrl_delay. It is parameterised by LATENCY, built on ctrl_reg, shifts start/valid/stop, and at LATENCY=0 is pure wiring.
- done is delayed alongside ctrl through the same structure.

Test Plan:
- LATENCY=0, req with len=4, stall=0 -> start at cycle 1; valid at cycles 2-5 with count 0,1,2,3; stop and done at cycle 6; busy high for cycles 1-6.
- len=3, stall high on the 2nd RUN cycle -> valid pattern 1,0,1,1; count 0,1,1,2; stop on the cycle after the third beat; exactly 3 valid beats.
- req with len=0 -> no start/valid/stop/done; busy stays 0. req asserted mid-burst (len=5, second req with len=2 at beat 2) -> burst stays 5 beats and the second req is dropped.
- LATENCY=2, len=2 -> ctrl.start, valid and stop each appear 2 cycles later than at LATENCY=0; count and busy are unshifted; done coincides with delayed stop.
- rst pulse during RUN at count=3 of len=8 -> all outputs 0 immediately, no stop or done, FSM in IDLE; a new req with len=2 after reset gives a clean 2-beat burst.
- Random len 1..300 with random stall, scoreboard -> valid count == len, start precedes the first valid, and stop directly follows the last valid, across 1000 bursts.
